// File: rtl/pi_pkg.sv
// rtl/pi_pkg.sv - shared state, ALU select codes, channel order and gain constants for the PI sequencer
package pi_pkg;

  typedef enum logic [3:0] {
    IDLE, SETTLE, CONV, ACC, ERR, INTG, ICMP, PCMP, RHT1, RHT2, LFT1, LFT2, DONE
  } pi_state_e;

  localparam logic [2:0] SRC1_ACCUM   = 3'd0;
  localparam logic [2:0] SRC1_ITERM   = 3'd1;
  localparam logic [2:0] SRC1_ERR     = 3'd2;
  localparam logic [2:0] SRC1_ERRDIV2 = 3'd3;
  localparam logic [2:0] SRC1_FWD     = 3'd4;
  localparam logic [2:0] SRC1_ZERO    = 3'd7;

  localparam logic [2:0] SRC0_A2D     = 3'd0;
  localparam logic [2:0] SRC0_INTGRL  = 3'd1;
  localparam logic [2:0] SRC0_ICOMP   = 3'd2;
  localparam logic [2:0] SRC0_PCOMP   = 3'd3;
  localparam logic [2:0] SRC0_PTERM   = 3'd4;
  localparam logic [2:0] SRC0_ZERO    = 3'd7;

  localparam logic [13:0] PTERM = 14'h3680;
  localparam logic [11:0] ITERM = 12'h500;

  // Even slots are the right-hand sensor of a pair, odd slots the left-hand one.
  function automatic logic [2:0] chan_of(input logic [2:0] idx);
    case (idx)
      3'd0:    chan_of = 3'd1;
      3'd1:    chan_of = 3'd0;
      3'd2:    chan_of = 3'd4;
      3'd3:    chan_of = 3'd2;
      3'd4:    chan_of = 3'd3;
      default: chan_of = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/pi_sequencer_settle_timer.sv
// rtl/pi_sequencer_settle_timer.sv - idle-cycle counter that expires on the last of CYC counted cycles
module settle_timer #(
  parameter int CYC = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic count,
  output logic expire
);

  localparam int W = (CYC > 1) ? $clog2(CYC) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    expire = count && (cnt_q == W'(CYC - 1));
    cnt_d  = '0;
    if (count && !expire) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pi_sequencer.sv
// rtl/pi_sequencer.sv - PI control sequencer: samples six sensors, steers an external ALU, updates motor commands
module pi_sequencer
  import pi_pkg::*;
#(
  parameter int          SETTLE_CYC = 32,
  parameter logic [11:0] FWD_MAX    = 12'h6A0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        cnv_cmplt,
  input  logic [11:0] A2D_res,
  input  logic [15:0] dst,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic [2:0]  src0sel,
  output logic [2:0]  src1sel,
  output logic        multiply,
  output logic        sub,
  output logic        mult2,
  output logic        mult4,
  output logic        saturate,
  output logic [15:0] Accum,
  output logic [15:0] Pcomp,
  output logic [11:0] Error,
  output logic [11:0] Intgrl,
  output logic [11:0] Icomp,
  output logic [11:0] Fwd,
  output logic [11:0] lft,
  output logic [11:0] rht,
  output logic        done
);

  pi_state_e   state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic        side_q, side_d;
  logic [1:0]  int_dec_q, int_dec_d;
  logic [11:0] a2d_q, a2d_d;
  logic [15:0] accum_q, accum_d, pcomp_q, pcomp_d;
  logic [11:0] error_q, error_d, intgrl_q, intgrl_d, icomp_q, icomp_d;
  logic [11:0] fwd_q, fwd_d, lft_q, lft_d, rht_q, rht_d;
  logic        settle_en, settle_expire;

  // The ALU reads A2D_res directly; the captured copy only records the last sample.
  logic        a2d_unused;
  assign a2d_unused = ^a2d_q;

  settle_timer #(.CYC(SETTLE_CYC)) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .count  (settle_en),
    .expire (settle_expire)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    side_d    = side_q;
    int_dec_d = int_dec_q;
    a2d_d     = a2d_q;
    accum_d   = accum_q;
    pcomp_d   = pcomp_q;
    error_d   = error_q;
    intgrl_d  = intgrl_q;
    icomp_d   = icomp_q;
    fwd_d     = fwd_q;
    lft_d     = lft_q;
    rht_d     = rht_q;
    src0sel   = SRC0_ZERO;
    src1sel   = SRC1_ZERO;
    multiply  = 1'b0;
    sub       = 1'b0;
    mult2     = 1'b0;
    mult4     = 1'b0;
    saturate  = 1'b0;
    strt_cnv  = 1'b0;
    done      = 1'b0;
    chnnl     = 3'd0;
    settle_en = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = SETTLE;
          accum_d = '0;
          k_d     = '0;
          side_d  = 1'b0;
        end
      end
      SETTLE: begin
        settle_en = 1'b1;
        chnnl     = chan_of({k_q, side_q});
        if (settle_expire) begin
          strt_cnv = 1'b1;
          state_d  = CONV;
        end
      end
      CONV: begin
        chnnl = chan_of({k_q, side_q});
        if (cnv_cmplt) begin
          a2d_d   = A2D_res;
          state_d = ACC;
        end
      end
      ACC: begin
        src1sel = SRC1_ACCUM;
        src0sel = SRC0_A2D;
        mult2   = (k_q == 2'd1);
        mult4   = (k_q == 2'd2);
        sub     = side_q;
        accum_d = dst;
        if (!side_q) begin
          side_d  = 1'b1;
          state_d = SETTLE;
        end else if (k_q == 2'd2) begin
          state_d = ERR;
        end else begin
          side_d  = 1'b0;
          k_d     = k_q + 2'd1;
          state_d = SETTLE;
        end
      end
      ERR: begin
        src1sel  = SRC1_ACCUM;
        src0sel  = SRC0_ZERO;
        saturate = 1'b1;
        error_d  = dst[11:0];
        state_d  = INTG;
      end
      INTG: begin
        // The integrator only accumulates every fourth pass.
        src1sel   = SRC1_ERRDIV2;
        src0sel   = SRC0_INTGRL;
        saturate  = 1'b1;
        if (int_dec_q == 2'd3) intgrl_d = dst[11:0];
        int_dec_d = int_dec_q + 2'd1;
        state_d   = ICMP;
      end
      ICMP: begin
        src1sel  = SRC1_ITERM;
        src0sel  = SRC0_INTGRL;
        multiply = 1'b1;
        icomp_d  = dst[11:0];
        state_d  = PCMP;
      end
      PCMP: begin
        src1sel  = SRC1_ERR;
        src0sel  = SRC0_PTERM;
        multiply = 1'b1;
        pcomp_d  = dst;
        state_d  = RHT1;
      end
      RHT1: begin
        src1sel = SRC1_FWD;
        src0sel = SRC0_PCOMP;
        sub     = 1'b1;
        accum_d = dst;
        state_d = RHT2;
      end
      RHT2: begin
        src1sel  = SRC1_ACCUM;
        src0sel  = SRC0_ICOMP;
        sub      = 1'b1;
        saturate = 1'b1;
        rht_d    = dst[11:0];
        state_d  = LFT1;
      end
      LFT1: begin
        src1sel = SRC1_FWD;
        src0sel = SRC0_PCOMP;
        accum_d = dst;
        state_d = LFT2;
      end
      LFT2: begin
        src1sel  = SRC1_ACCUM;
        src0sel  = SRC0_ICOMP;
        saturate = 1'b1;
        lft_d    = dst[11:0];
        state_d  = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (go) begin
          fwd_d   = (fwd_q < FWD_MAX) ? fwd_q + 12'd1 : fwd_q;
          accum_d = '0;
          k_d     = '0;
          side_d  = 1'b0;
          state_d = SETTLE;
        end else begin
          fwd_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      side_q    <= 1'b0;
      int_dec_q <= '0;
      a2d_q     <= '0;
      accum_q   <= '0;
      pcomp_q   <= '0;
      error_q   <= '0;
      intgrl_q  <= '0;
      icomp_q   <= '0;
      fwd_q     <= '0;
      lft_q     <= '0;
      rht_q     <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      side_q    <= side_d;
      int_dec_q <= int_dec_d;
      a2d_q     <= a2d_d;
      accum_q   <= accum_d;
      pcomp_q   <= pcomp_d;
      error_q   <= error_d;
      intgrl_q  <= intgrl_d;
      icomp_q   <= icomp_d;
      fwd_q     <= fwd_d;
      lft_q     <= lft_d;
      rht_q     <= rht_d;
    end
  end

  assign Accum  = accum_q;
  assign Pcomp  = pcomp_q;
  assign Error  = error_q;
  assign Intgrl = intgrl_q;
  assign Icomp  = icomp_q;
  assign Fwd    = fwd_q;
  assign lft    = lft_q;
  assign rht    = rht_q;

endmodule

// File: tb/tb_pi_sequencer.sv
// tb/tb_pi_sequencer.sv - directed bench for pi_sequencer with an ALU and A2D model alongside
module tb_pi_sequencer;
  import pi_pkg::*;

  localparam int          SETTLE_CYC = 4;
  localparam logic [11:0] FWD_MAX    = 12'h008;
  localparam int          CONV_LAT   = 3;

  logic        clk = 1'b0;
  logic        rst, go, cnv_cmplt;
  logic [11:0] A2D_res;
  logic [15:0] dst;
  logic        strt_cnv, multiply, sub, mult2, mult4, saturate, done;
  logic [2:0]  chnnl, src0sel, src1sel;
  logic [15:0] Accum, Pcomp;
  logic [11:0] Error, Intgrl, Icomp, Fwd, lft, rht;

  pi_sequencer #(.SETTLE_CYC(SETTLE_CYC), .FWD_MAX(FWD_MAX)) dut (
    .clk(clk), .rst(rst), .go(go), .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res), .dst(dst),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .src0sel(src0sel), .src1sel(src1sel),
    .multiply(multiply), .sub(sub), .mult2(mult2), .mult4(mult4), .saturate(saturate),
    .Accum(Accum), .Pcomp(Pcomp), .Error(Error), .Intgrl(Intgrl), .Icomp(Icomp),
    .Fwd(Fwd), .lft(lft), .rht(rht), .done(done)
  );

  always #5 clk = ~clk;

  // Reference ALU: sign-extended operands, shift/subtract, 12-bit saturation, Q12 multiply.
  logic [15:0]        a_src1, a_src0, a_scaled, a_sum;
  logic signed [29:0] a_prod;
  int                 a_sum_i;
  always_comb begin
    case (src1sel)
      SRC1_ACCUM:   a_src1 = Accum;
      SRC1_ITERM:   a_src1 = {4'b0, ITERM};
      SRC1_ERR:     a_src1 = {{4{Error[11]}}, Error};
      SRC1_ERRDIV2: a_src1 = {{5{Error[11]}}, Error[11:1]};
      SRC1_FWD:     a_src1 = {4'b0, Fwd};
      default:      a_src1 = 16'h0000;
    endcase
    case (src0sel)
      SRC0_A2D:    a_src0 = {4'b0, A2D_res};
      SRC0_INTGRL: a_src0 = {{4{Intgrl[11]}}, Intgrl};
      SRC0_ICOMP:  a_src0 = {{4{Icomp[11]}}, Icomp};
      SRC0_PCOMP:  a_src0 = Pcomp;
      SRC0_PTERM:  a_src0 = {2'b0, PTERM};
      default:     a_src0 = 16'h0000;
    endcase
    a_scaled = mult4 ? {a_src0[13:0], 2'b00} : (mult2 ? {a_src0[14:0], 1'b0} : a_src0);
    a_sum    = sub ? a_src1 - a_scaled : a_src1 + a_scaled;
    a_sum_i  = int'($signed(a_sum));
    a_prod   = $signed(a_src1[14:0]) * $signed(a_src0[14:0]);
    if (multiply) begin
      if (a_prod[29] && !(&a_prod[28:26]))      dst = 16'hC000;
      else if (!a_prod[29] && (|a_prod[28:26])) dst = 16'h3FFF;
      else                                      dst = a_prod[27:12];
    end else if (saturate) begin
      if (a_sum_i > 2047)       dst = 16'h07FF;
      else if (a_sum_i < -2048) dst = 16'hF800;
      else                      dst = a_sum;
    end else begin
      dst = a_sum;
    end
  end

  // A2D model: answers each strt_cnv after CONV_LAT cycles unless hold_cnv freezes it.
  logic [11:0] a2d_val [8];
  logic        hold_cnv;
  logic [2:0]  cnv_ch;
  int          pend, strt_seen, done_cnt;
  initial begin
    cnv_cmplt = 1'b0; A2D_res = 12'h000; pend = 0; strt_seen = 0; cnv_ch = 3'd0;
    forever begin
      @(negedge clk);
      cnv_cmplt = 1'b0;
      if (rst) pend = 0;
      else if (pend != 0 && !hold_cnv) begin
        pend = pend - 1;
        if (pend == 0) begin
          cnv_cmplt = 1'b1;
          A2D_res   = a2d_val[cnv_ch];
        end
      end
      if (strt_cnv && !rst) begin
        strt_seen = strt_seen + 1;
        cnv_ch    = chnnl;
        pend      = CONV_LAT;
      end
    end
  end

  initial begin
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (done) done_cnt = done_cnt + 1;
    end
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; go = 1'b0; hold_cnv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_a2d(input logic [11:0] r, input logic [11:0] l);
    a2d_val[1] = r; a2d_val[4] = r; a2d_val[3] = r;
    a2d_val[0] = l; a2d_val[2] = l; a2d_val[7] = l;
  endtask

  task automatic wait_done(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: no done pulse within 2000 cycles", name);
    end
  endtask

  task automatic time_settle(input string name);
    int n;
    n = 0;
    while (!strt_cnv && n < 100) begin @(negedge clk); n++; end
    check({name, " settle cycles"}, 32'(n), 32'(SETTLE_CYC));
    check({name, " first chnnl"}, 32'(chnnl), 32'h1);
  endtask

  typedef struct packed {
    logic [11:0] r;
    logic [11:0] l;
    logic [11:0] err;
    logic [15:0] pcomp;
    logic [11:0] rht;
    logic [11:0] lft;
  } vec_t;

  vec_t vecs [5];
  bit   ok;
  int   d0, bad_state, bad_ch, bad_strt, s0;

  initial begin
    vecs[0] = '{r:12'h100, l:12'h100, err:12'h000, pcomp:16'h0000, rht:12'h000, lft:12'h000};
    vecs[1] = '{r:12'h200, l:12'h000, err:12'h7FF, pcomp:16'h1B3C, rht:12'h800, lft:12'h7FF};
    vecs[2] = '{r:12'h000, l:12'h200, err:12'h800, pcomp:16'hE4C0, rht:12'h7FF, lft:12'h800};
    vecs[3] = '{r:12'h010, l:12'h008, err:12'h038, pcomp:16'h00BE, rht:12'hF42, lft:12'h0BE};
    vecs[4] = '{r:12'h030, l:12'h040, err:12'hF90, pcomp:16'hFE82, rht:12'h17E, lft:12'hE82};
    for (int i = 0; i < 8; i++) a2d_val[i] = 12'h000;

    rst = 1'b1; go = 1'b0; hold_cnv = 1'b0;
    repeat (2) @(negedge clk);
    check("reset Accum/Pcomp", {Accum, Pcomp}, 32'h0);
    check("reset Error/Intgrl", 32'({Error, Intgrl}), 32'h0);
    check("reset Icomp/Fwd", 32'({Icomp, Fwd}), 32'h0);
    check("reset lft/rht", 32'({lft, rht}), 32'h0);
    check("reset pulses/ctrl", 32'({strt_cnv, done, chnnl, multiply, sub, mult2, mult4, saturate}), 32'h0);
    check("idle src sels", 32'({src1sel, src0sel}), 32'h3F);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      set_a2d(vecs[v].r, vecs[v].l);
      d0 = done_cnt;
      go = 1'b1;
      wait_done($sformatf("vec%0d", v), ok);
      if (ok) begin
        check($sformatf("vec%0d Error", v), 32'(Error), 32'(vecs[v].err));
        check($sformatf("vec%0d Pcomp", v), 32'(Pcomp), 32'(vecs[v].pcomp));
        check($sformatf("vec%0d rht", v), 32'(rht), 32'(vecs[v].rht));
        check($sformatf("vec%0d lft", v), 32'(lft), 32'(vecs[v].lft));
        check($sformatf("vec%0d Icomp", v), 32'(Icomp), 32'h0);
        @(negedge clk);
        check($sformatf("vec%0d Fwd after done", v), 32'(Fwd), 32'h1);
        check($sformatf("vec%0d done pulses", v), 32'(done_cnt - d0), 32'h1);
      end
      go = 1'b0;
    end

    // Conversion withheld: FSM parks in CONV with the channel held and no new request.
    do_reset();
    set_a2d(12'h100, 12'h100);
    hold_cnv = 1'b1;
    go = 1'b1;
    time_settle("hold");
    s0 = strt_seen; bad_state = 0; bad_ch = 0; bad_strt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (dut.state_q != CONV) bad_state++;
      if (chnnl != 3'd1) bad_ch++;
      if (strt_cnv) bad_strt++;
    end
    check("hold cycles outside CONV", 32'(bad_state), 32'h0);
    check("hold chnnl changes", 32'(bad_ch), 32'h0);
    check("hold strt_cnv in CONV", 32'(bad_strt), 32'h0);
    check("hold extra requests", 32'(strt_seen - s0), 32'h0);
    hold_cnv = 1'b0;
    wait_done("hold release", ok);
    if (ok) check("hold release Error", 32'(Error), 32'h0);
    go = 1'b0;

    // Integrator updates only on the fourth pass.
    do_reset();
    set_a2d(12'h200, 12'h000);
    go = 1'b1;
    for (int p = 0; p < 4; p++) begin
      wait_done($sformatf("intg pass%0d", p), ok);
      if (ok) begin
        check($sformatf("intg pass%0d Intgrl", p), 32'(Intgrl), (p == 3) ? 32'h3FF : 32'h0);
        check($sformatf("intg pass%0d Fwd", p), 32'(Fwd), 32'(p));
        if (p == 3) check("intg pass3 Icomp", 32'(Icomp), 32'h13F);
      end
    end
    go = 1'b0;

    // Forward speed ramps to its ceiling, holds, and clears when go drops.
    do_reset();
    set_a2d(12'h100, 12'h100);
    go = 1'b1;
    for (int p = 0; p <= 10; p++) begin
      wait_done($sformatf("fwd pass%0d", p), ok);
      if (ok) begin
        check($sformatf("fwd pass%0d Fwd", p), 32'(Fwd), (p < 8) ? 32'(p) : 32'(FWD_MAX));
        check($sformatf("fwd pass%0d rht", p), 32'(rht), (p < 8) ? 32'(p) : 32'(FWD_MAX));
      end
      if (p == 10) go = 1'b0;
    end
    @(negedge clk);
    check("fwd cleared on stop", 32'(Fwd), 32'h0);
    check("fwd stop to IDLE", 32'(dut.state_q), 32'(IDLE));

    // Reset in the middle of a pass.
    do_reset();
    set_a2d(12'h200, 12'h000);
    go = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (dut.state_q == PCMP) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL midrst: PCMP not reached within 2000 cycles");
    end
    check("midrst Error before", 32'(Error), 32'h7FF);
    check("midrst Accum before", 32'(Accum), 32'hE00);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("midrst Accum/Pcomp", {Accum, Pcomp}, 32'h0);
    check("midrst Error/Icomp", 32'({Error, Icomp}), 32'h0);
    check("midrst ctrl", 32'({multiply, done, strt_cnv, chnnl}), 32'h0);
    check("midrst state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0; go = 1'b0;
    repeat (50) @(negedge clk);
    check("midrst no done", 32'(done_cnt - d0), 32'h0);
    go = 1'b1;
    time_settle("restart");
    wait_done("restart", ok);
    if (ok) begin
      check("restart Error", 32'(Error), 32'h7FF);
      check("restart Pcomp", 32'(Pcomp), 32'h1B3C);
      check("restart rht/lft", 32'({rht, lft}), 32'h8007FF);
      check("restart Fwd", 32'(Fwd), 32'h0);
    end
    go = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pi_sequencer.md
PI_SEQUENCER -- requirements
Module: pi_sequencer

Interface
REQ-001 Parameters SHALL be: SETTLE_CYC, default 32, idle cycles before each A2D conversion; FWD_MAX, default 12'h6A0, forward-speed ceiling.
REQ-002 Port clk  in  1  system clock; all state on rising edge.
REQ-003 Port rst  in  1  reset, asynchronous, active-high.
REQ-004 Port go  in  1  enable; high starts and repeats PI passes.
REQ-005 Port cnv_cmplt  in  1  A2D conversion done pulse.
REQ-006 Port A2D_res  in  12  unsigned A2D result, valid when cnv_cmplt is high.
REQ-007 Port dst  in  16  ALU result, combinational from the outputs below.
REQ-008 Ports strt_cnv (out 1) and chnnl (out 3) SHALL carry the conversion request pulse and the channel select.
REQ-009 Ports src0sel and src1sel (out 3 each) and multiply, sub, mult2, mult4, saturate (out 1 each) SHALL be the ALU controls.
REQ-010 Ports Accum and Pcomp (out 16), and Error, Intgrl, Icomp and Fwd (out 12) SHALL be the ALU operand registers.
REQ-011 Ports lft and rht (out 12) SHALL be the signed saturated motor commands; done (out 1) SHALL be the pass-complete pulse.

Function
REQ-012 States SHALL be IDLE, SETTLE, CONV, ACC, ERR, INTG, ICMP, PCMP, RHT1, RHT2, LFT1, LFT2 and DONE.
REQ-013 IDLE -> SETTLE SHALL occur when go=1, with Accum cleared to 0 and the pair index k cleared to 0.
REQ-014 SETTLE SHALL count SETTLE_CYC cycles, then pulse strt_cnv for 1 cycle and enter CONV.
REQ-015 Channel order SHALL be 1, 0, 4, 2, 3, 7, with the first channel of each pair taken as right and the second as left.
REQ-016 CONV SHALL hold chnnl and wait indefinitely for cnv_cmplt; on cnv_cmplt it SHALL latch A2D_res and enter ACC.
REQ-017 ACC SHALL drive src1sel=Accum(0) and src0sel=A2D(0), with mult2 for k=1, mult4 for k=2, and sub for the left channel, and SHALL load Accum<=dst.
REQ-018 After ACC, the FSM SHALL return to SETTLE until all 6 channels are done, then enter ERR.
REQ-019 ERR SHALL drive src1sel=Accum(0), src0sel=7 (zero) and saturate, and SHALL load Error<=dst[11:0].
REQ-020 INTG SHALL drive src1sel=ErrDiv2(3), src0sel=Intgrl(1) and saturate, and SHALL load Intgrl only when the 2-bit int_dec counter is 3; int_dec SHALL increment once per pass and wrap.
REQ-021 ICMP SHALL drive src1sel=Iterm(1), src0sel=Icomp... no: src0sel=Intgrl(1) with multiply, and SHALL load Icomp<=dst[11:0].
REQ-022 PCMP SHALL drive src1sel=Err(2), src0sel=Pterm(4) with multiply, and SHALL load Pcomp<=dst.
REQ-023 RHT1 SHALL compute Fwd-Pcomp into Accum; RHT2 SHALL compute Accum-Icomp with saturate into rht.
REQ-024 LFT1 SHALL compute Fwd+Pcomp into Accum; LFT2 SHALL compute Accum+Icomp with saturate into lft.
REQ-025 DONE SHALL pulse done for 1 cycle and increment Fwd by 1 if Fwd<FWD_MAX, leaving it unchanged at FWD_MAX.
REQ-026 DONE SHALL go to SETTLE (new pass, Accum cleared) if go=1, else to IDLE with Fwd cleared to 0.
REQ-027 go falling mid-pass SHALL NOT abort the pass; go SHALL be sampled only in IDLE and DONE.
REQ-028 In any state not listed above, ALU controls SHALL be 0, with src0sel and src1sel equal to 3'b111.
REQ-029 Operand and command registers SHALL change only in their own state.
REQ-030 strt_cnv SHALL never be high while in CONV.

Reset
REQ-031 On rst, the FSM SHALL go to IDLE, and all registers, outputs, counters, k and int_dec SHALL be 0, effective immediately and asynchronously.
REQ-032 rst mid-pass SHALL discard the pass, with no done pulse and a later pass restarting from SETTLE.

Structure
REQ-033 Package pi_pkg SHALL hold the state enum, the ALU src0/src1 select codes, the channel-order table, and the fixed Pterm=14'h3680 and Iterm=12'h500.
REQ-034 The sub-module settle_timer (count/expire) SHALL be instantiated once; the ALU SHALL be instantiated beside it by the parent, not inside.

Verification
REQ-035 With all A2D=0x100 and go held for one pass: Error=0, lft=rht=0x000, done pulse seen, Fwd=1.
REQ-036 With right channels=0x200 and left=0x000: Error=0x7FF, Pcomp=0x1B3C, rht=0x800, lft=0x7FF.
REQ-037 For 4 consecutive passes: Intgrl SHALL change only on the 4th pass.
REQ-038 With Fwd preset to FWD_MAX via repeated passes: Fwd stays 0x6A0; deasserting go gives Fwd=0 after DONE.
REQ-039 With cnv_cmplt withheld 1000 cycles: the FSM stays in CONV with chnnl stable and no extra strt_cnv.
REQ-040 With rst asserted during PCMP: all outputs 0 in the same cycle, no done pulse, and a clean restart on go.
